// File: rtl/fifo_wr_adapter.sv
// Write-side front end for the async FIFO: 2-entry skid buffer, winc/wdata drive, write statistics.
// Optional full-timeout flush into a DROP state is enabled by defining FIFO_WR_TIMEOUT_EN.
module fifo_wr_adapter #(
    parameter int DATA_LINES = 8,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  s_valid,
    input  logic [DATA_LINES-1:0] s_data,
    output logic                  s_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DATA_LINES-1:0] wdata,
    input  logic                  clr_stats,
    output logic [CNT_W-1:0]      wr_count,
    output logic [CNT_W-1:0]      drop_count,
    output logic                  stall,
    output logic                  timeout
);
    // state | meaning
    // IDLE  | buffer empty
    // RUN   | words buffered, FIFO accepting
    // STALL | words buffered, FIFO full
    // DROP  | flushed after timeout; pushes discarded until clr_stats
    typedef enum logic [1:0] {IDLE, RUN, STALL, DROP} state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_LINES-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
    logic [CNT_W-1:0]      wr_count_q, wr_count_d;
    logic                  stall_q, stall_d;
    logic                  push, store, pop, timeout_hit;

    assign s_ready  = (state_q == DROP) || (cnt_q != 2'd2);
    assign push     = s_valid & s_ready;
    assign store    = push & (state_q != DROP);
    assign winc     = (cnt_q != 2'd0) & ~wfull & (state_q != DROP);
    assign pop      = winc;
    assign wdata    = mem0_q;
    assign wr_count = wr_count_q;
    assign stall    = stall_q;

`ifdef FIFO_WR_TIMEOUT_EN
    localparam int SC_W = $clog2(TIMEOUT) + 1;

    logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;
    logic             timeout_q, timeout_d;
    logic [1:0]       drop_add;
    logic [CNT_W:0]   drop_sum;

    // a coincident clr_stats restarts the statistics instead of flushing
    assign timeout_hit = (state_q == STALL) && (stall_cnt_q == SC_W'(TIMEOUT - 1))
                         && wfull && ~clr_stats;
    assign drop_count  = drop_count_q;
    assign timeout     = timeout_q;

    always_comb begin
        drop_add = 2'd0;
        if (timeout_hit)
            drop_add = cnt_q + {1'b0, store};
        else if (state_q == DROP && push)
            drop_add = 2'd1;
        drop_sum = {1'b0, drop_count_q} + {{(CNT_W-1){1'b0}}, drop_add};

        if (clr_stats)
            drop_count_d = '0;
        else if (drop_sum[CNT_W])
            drop_count_d = '1;
        else
            drop_count_d = drop_sum[CNT_W-1:0];

        timeout_d = clr_stats ? 1'b0 : (timeout_hit | timeout_q);

        stall_cnt_d = '0;
        if (state_q == STALL && state_d == STALL)
            stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 1'b1;
    end

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            stall_cnt_q  <= '0;
            drop_count_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            drop_count_q <= drop_count_d;
            timeout_q    <= timeout_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign drop_count  = '0;
    assign timeout     = 1'b0;
`endif

    always_comb begin
        cnt_d   = cnt_q;
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        state_d = state_q;

        // entry 0 is always the head; a pop shifts entry 1 forward
        if (timeout_hit) begin
            cnt_d = 2'd0;
        end else begin
            case ({store, pop})
                2'b10: begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd0) mem0_d = s_data;
                    else               mem1_d = s_data;
                end
                2'b01: begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd2) mem0_d = mem1_q;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        mem0_d = s_data;
                    end else begin
                        mem0_d = mem1_q;
                        mem1_d = s_data;
                    end
                end
                default: ;
            endcase
        end

        case (state_q)
            IDLE:    if (store) state_d = RUN;
            RUN: begin
                if (cnt_d == 2'd0) state_d = IDLE;
                else if (wfull)    state_d = STALL;
            end
            STALL: begin
                if (timeout_hit)   state_d = DROP;
                else if (!wfull)   state_d = (cnt_d == 2'd0) ? IDLE : RUN;
            end
            DROP:    if (clr_stats) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        stall_d    = (state_d == STALL);
        wr_count_d = clr_stats ? '0 : (winc ? wr_count_q + 1'b1 : wr_count_q);
    end

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            mem0_q     <= '0;
            mem1_q     <= '0;
            wr_count_q <= '0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem0_q     <= mem0_d;
            mem1_q     <= mem1_d;
            wr_count_q <= wr_count_d;
            stall_q    <= stall_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_adapter.sv
// Directed bench for fifo_wr_adapter; the timeout scenario runs when FIFO_WR_TIMEOUT_EN is defined.
module tb_fifo_wr_adapter;
    logic        wclk = 1'b0;
    logic        wrst = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        wfull = 1'b0;
    logic        winc;
    logic [7:0]  wdata;
    logic        clr_stats = 1'b0;
    logic [15:0] wr_count;
    logic [15:0] drop_count;
    logic        stall;
    logic        timeout;

    int nerr = 0;
    int nchk = 0;

    fifo_wr_adapter #(.DATA_LINES(8), .CNT_W(16), .TIMEOUT(4)) dut (
        .wclk(wclk), .wrst(wrst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .wfull(wfull), .winc(winc), .wdata(wdata), .clr_stats(clr_stats),
        .wr_count(wr_count), .drop_count(drop_count), .stall(stall), .timeout(timeout)
    );

    always #5 wclk = ~wclk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic neg();
        @(negedge wclk);
    endtask

    logic [7:0] q[$];
    int sent, written, bad_full, bad_order, cyc, bad;

    initial begin
        // reset values
        #12;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_winc", winc, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_stall", stall, 0);
        chk("rst_timeout", timeout, 0);
        #1 wrst = 1'b1;
        step();

        // 1: three back-to-back words, one cycle latency
        s_valid = 1'b1; s_data = 8'h11;
        neg(); chk("t1_winc_c0", winc, 0);
        step(); s_data = 8'h22;
        neg(); chk("t1_winc_c1", winc, 1); chk("t1_wdata_c1", wdata, 8'h11);
        step(); s_data = 8'h33;
        neg(); chk("t1_winc_c2", winc, 1); chk("t1_wdata_c2", wdata, 8'h22);
        step(); s_valid = 1'b0;
        neg(); chk("t1_winc_c3", winc, 1); chk("t1_wdata_c3", wdata, 8'h33);
        step();
        neg(); chk("t1_winc_c4", winc, 0); chk("t1_wr_count", wr_count, 3);
        chk("t1_wdata_hold", wdata, 8'h33);

        // 2: fill while full, then release
        step(); wfull = 1'b1; s_valid = 1'b1; s_data = 8'hA1;
        neg(); step(); s_data = 8'hA2;
        neg(); chk("t2_ready_cnt1", s_ready, 1); chk("t2_winc_full", winc, 0);
        step(); s_valid = 1'b0;
        neg(); chk("t2_ready_cnt2", s_ready, 0); chk("t2_stall", stall, 1);
        chk("t2_winc_full2", winc, 0);
        step();
        neg(); chk("t2_stall_hold", stall, 1);
        step(); wfull = 1'b0;
        neg(); chk("t2_winc_a1", winc, 1); chk("t2_wdata_a1", wdata, 8'hA1);
        step();
        neg(); chk("t2_winc_a2", winc, 1); chk("t2_wdata_a2", wdata, 8'hA2);
        chk("t2_stall_run", stall, 0);
        step();
        neg(); chk("t2_winc_done", winc, 0); chk("t2_wr_count", wr_count, 5);
        chk("t2_ready_idle", s_ready, 1);

        // clear coinciding with a write: the clear wins
        step(); s_valid = 1'b1; s_data = 8'h77;
        neg(); step(); s_valid = 1'b0; clr_stats = 1'b1;
        neg(); chk("clr_winc", winc, 1);
        step(); clr_stats = 1'b0;
        neg(); chk("clr_wr_count", wr_count, 0);

        // 3: 300 words with wfull toggling every 3 cycles
        sent = 0; written = 0; bad_full = 0; bad_order = 0; cyc = 0;
        step();
        while (written < 300 && cyc < 3000) begin
            wfull   = ((cyc / 3) % 2) == 1;
            s_valid = (sent < 300);
            s_data  = sent[7:0] ^ 8'h5A;
            neg();
            if (winc) begin
                if (wfull) bad_full++;
                if (q.size() == 0) bad_order++;
                else begin
                    if (wdata !== q[0]) bad_order++;
                    void'(q.pop_front());
                end
                written++;
            end
            if (s_valid && s_ready) begin
                q.push_back(s_data);
                sent++;
            end
            step();
            cyc++;
        end
        s_valid = 1'b0; wfull = 1'b0;
        chk("t3_winc_while_full", bad_full, 0);
        chk("t3_order", bad_order, 0);
        chk("t3_written", written, 300);
        chk("t3_leftover", q.size(), 0);
        neg(); chk("t3_wr_count", wr_count, 300);

        // 4: reset with two words buffered
        step(); wfull = 1'b1; s_valid = 1'b1; s_data = 8'hB1;
        neg(); step(); s_data = 8'hB2;
        neg(); step(); s_valid = 1'b0;
        neg(); chk("t4_ready_full", s_ready, 0);
        #2 wrst = 1'b0; wfull = 1'b0;
        #1;
        chk("t4_rst_ready", s_ready, 1);
        chk("t4_rst_winc", winc, 0);
        chk("t4_rst_wdata", wdata, 0);
        chk("t4_rst_wr_count", wr_count, 0);
        chk("t4_rst_stall", stall, 0);
        chk("t4_rst_timeout", timeout, 0);
        chk("t4_rst_drop", drop_count, 0);
        #1 wrst = 1'b1;
        step(); s_valid = 1'b1; s_data = 8'hC1;
        neg(); step(); s_valid = 1'b0;
        neg(); chk("t4_first_winc", winc, 1); chk("t4_first_wdata", wdata, 8'hC1);
        step();
        neg(); chk("t4_after_winc", winc, 0); chk("t4_wr_count", wr_count, 1);

`ifdef FIFO_WR_TIMEOUT_EN
        // 5: timeout flush after 4 stall cycles, DROP until clr_stats
        step(); wfull = 1'b1; s_valid = 1'b1; s_data = 8'hD1;
        neg(); step(); s_data = 8'hD2;
        neg(); step(); s_valid = 1'b0;
        neg(); chk("t5_stall_c2", stall, 1);
        step(); step(); step();
        neg(); chk("t5_stall_c5", stall, 1); chk("t5_no_timeout_c5", timeout, 0);
        step(); wfull = 1'b0; s_valid = 1'b1; s_data = 8'hE1;
        neg(); chk("t5_timeout", timeout, 1); chk("t5_drop2", drop_count, 2);
        chk("t5_ready_drop", s_ready, 1); chk("t5_winc_drop", winc, 0);
        chk("t5_stall_drop", stall, 0);
        step(); s_data = 8'hE2;
        neg(); step(); s_data = 8'hE3;
        neg(); chk("t5_winc_drop2", winc, 0);
        step(); s_valid = 1'b0; clr_stats = 1'b1;
        neg(); chk("t5_drop5", drop_count, 5); chk("t5_timeout_hold", timeout, 1);
        chk("t5_winc_drop3", winc, 0);
        step(); clr_stats = 1'b0; s_valid = 1'b1; s_data = 8'hF1;
        neg(); chk("t5_clr_drop", drop_count, 0); chk("t5_clr_timeout", timeout, 0);
        chk("t5_clr_wr_count", wr_count, 0); chk("t5_clr_stall", stall, 0);
        step(); s_valid = 1'b0;
        neg(); chk("t5_idle_winc", winc, 1); chk("t5_idle_wdata", wdata, 8'hF1);
        step();
`else
        // 6: without the flush, STALL holds indefinitely
        step(); wfull = 1'b1; s_valid = 1'b1; s_data = 8'h61;
        neg(); step(); s_data = 8'h62;
        neg(); step(); s_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            neg();
            if (stall !== 1'b1 || timeout !== 1'b0 || s_ready !== 1'b0 || winc !== 1'b0
                || drop_count !== 16'h0) bad++;
            step();
        end
        chk("t6_bad_stall_cycles", bad, 0);
        wfull = 1'b0;
        neg(); chk("t6_winc_g1", winc, 1); chk("t6_wdata_g1", wdata, 8'h61);
        step();
        neg(); chk("t6_winc_g2", winc, 1); chk("t6_wdata_g2", wdata, 8'h62);
        step();
        neg(); chk("t6_done", winc, 0); chk("t6_wr_count", wr_count, 3);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
